// File: rtl/ahb_sram_slave_if.sv
// rtl/ahb_sram_slave_if.sv - AHB-Lite bus bundle between a master and ahb_sram_slave
//
// Purpose: groups the address/data-phase signals of one AHB-Lite slave port.
// Signals:
//   HSEL         slave select
//   HADDR_i      byte address (ADDR_W)
//   HWRITE_i     1 = write, 0 = read
//   HSIZE_i      transfer size (000 byte .. 011 dword)
//   HTRANS_i     transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HREADY_i     bus-level ready
//   HWDATA_i     write data, data phase (DATA_W)
//   HREADYOUT_o  slave transfer-complete
//   HRESP_o      0 = OKAY, 1 = ERROR
//   HRDATA_o     read data (DATA_W)
// Modports: master drives the request side, slave drives the response side.
interface ahb_sram_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR_i;
  logic              HWRITE_i;
  logic [2:0]        HSIZE_i;
  logic [1:0]        HTRANS_i;
  logic              HREADY_i;
  logic [DATA_W-1:0] HWDATA_i;
  logic              HREADYOUT_o;
  logic              HRESP_o;
  logic [DATA_W-1:0] HRDATA_o;

  modport master (
    output HSEL, HADDR_i, HWRITE_i, HSIZE_i, HTRANS_i, HREADY_i, HWDATA_i,
    input  HREADYOUT_o, HRESP_o, HRDATA_o
  );

  modport slave (
    input  HSEL, HADDR_i, HWRITE_i, HSIZE_i, HTRANS_i, HREADY_i, HWDATA_i,
    output HREADYOUT_o, HRESP_o, HRDATA_o
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite SRAM slave with configurable wait states and error responses
//
// Purpose: single-port word memory behind an AHB-Lite slave port. Byte, half,
// word (and dword when DATA_W=64) transfers with little-endian lane selection,
// optional fixed wait states per transfer, two-cycle ERROR response for
// oversized transfers, write-to-read forwarding for back-to-back accesses.
// Ports:
//   HCLK_i     clock, rising edge
//   HRESETn_i  synchronous active-low reset (memory contents are kept)
//   bus        ahb_sram_slave_if.slave (HSEL, HADDR_i, HWRITE_i, HSIZE_i,
//              HTRANS_i, HREADY_i, HWDATA_i -> HREADYOUT_o, HRESP_o, HRDATA_o)
// Parameters: DATA_W (32/64), ADDR_W, DEPTH (power of two), WAIT_CYCLES (0..7).
// Macro AHB_SRAM_ADDR_ERR_EN: when defined, word addresses at or beyond DEPTH
// get an ERROR response; otherwise they wrap modulo DEPTH with OKAY.
module ahb_sram_slave #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input logic             HCLK_i,
  input logic             HRESETn_i,
  ahb_sram_slave_if.slave bus
);

  localparam int         NB        = DATA_W / 8;
  localparam int         BL        = $clog2(NB);
  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [2:0] MAX_SIZE  = 3'(BL);
  localparam logic [2:0] WAIT_INIT = 3'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t            state;
  logic [2:0]        wait_cnt;
  logic [IDX_W-1:0]  ph_idx;
  logic              ph_write;
  logic [NB-1:0]     ph_mask;
  logic              ready_q;
  logic              resp_q;
  logic [DATA_W-1:0] rdata_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              slot_open;
  logic              accept;
  logic              size_err;
  logic              addr_err;
  logic [IDX_W-1:0]  new_idx;
  logic [NB-1:0]     new_mask;
  logic              commit;
  logic [DATA_W-1:0] merged;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] fwd_word;
  logic              unused_bits;

  assign bus.HREADYOUT_o = ready_q;
  assign bus.HRESP_o     = resp_q;
  assign bus.HRDATA_o    = rdata_q;

  // A new address phase can only complete in cycles where this slave is not
  // stalling the bus: idle, the last data cycle, or the second error cycle.
  assign slot_open = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign accept    = slot_open && bus.HSEL && bus.HREADY_i && bus.HTRANS_i[1];
  assign size_err  = bus.HSIZE_i > MAX_SIZE;
  assign new_idx   = bus.HADDR_i[IDX_W+BL-1:BL];

`ifdef AHB_SRAM_ADDR_ERR_EN
  assign addr_err = (bus.HADDR_i >> BL) >= ADDR_W'(DEPTH);
`else
  assign addr_err = 1'b0;
`endif

  assign unused_bits = ^{bus.HTRANS_i[0], bus.HADDR_i};

  // A lane belongs to the transfer when it sits in the same size-aligned
  // block as the (possibly unaligned) address, which aligns the address down.
  always_comb begin
    new_mask = '0;
    for (int b = 0; b < NB; b++) begin
      if ((b >> bus.HSIZE_i) == (int'(bus.HADDR_i[BL-1:0]) >> bus.HSIZE_i)) begin
        new_mask[b] = 1'b1;
      end
    end
  end

  assign commit = (state == S_DATA) && ph_write;

  always_comb begin
    merged = mem[ph_idx];
    for (int b = 0; b < NB; b++) begin
      if (ph_mask[b]) begin
        merged[8*b +: 8] = bus.HWDATA_i[8*b +: 8];
      end
    end
  end

  // Read data is captured on the edge entering DATA. If a write to the same
  // word commits on that same edge, the merged value is used instead of the
  // stale array contents.
  assign rd_idx   = (state == S_WAIT) ? ph_idx : new_idx;
  assign fwd_word = (commit && (ph_idx == rd_idx)) ? merged : mem[rd_idx];

  always_ff @(posedge HCLK_i) begin
    if (HRESETn_i && commit) begin
      mem[ph_idx] <= merged;
    end
  end

  always_ff @(posedge HCLK_i) begin
    if (!HRESETn_i) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      ready_q  <= 1'b1;
      resp_q   <= 1'b0;
      rdata_q  <= '0;
      ph_idx   <= '0;
      ph_write <= 1'b0;
      ph_mask  <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (wait_cnt == 3'd0) begin
            state   <= S_DATA;
            ready_q <= 1'b1;
            rdata_q <= ph_write ? '0 : fwd_word;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end

        S_ERR1: begin
          state   <= S_ERR2;
          ready_q <= 1'b1;
          resp_q  <= 1'b1;
        end

        default: begin
          state    <= S_IDLE;
          ready_q  <= 1'b1;
          resp_q   <= 1'b0;
          rdata_q  <= '0;
          ph_write <= 1'b0;
          if (accept) begin
            if (size_err || addr_err) begin
              state   <= S_ERR1;
              ready_q <= 1'b0;
              resp_q  <= 1'b1;
            end else begin
              ph_idx   <= new_idx;
              ph_write <= bus.HWRITE_i;
              ph_mask  <= new_mask;
              if (WAIT_CYCLES > 0) begin
                state    <= S_WAIT;
                ready_q  <= 1'b0;
                wait_cnt <= WAIT_INIT;
              end else begin
                state   <= S_DATA;
                rdata_q <= bus.HWRITE_i ? '0 : fwd_word;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - self-checking bench for ahb_sram_slave (WAIT_CYCLES 0 and 3)
module tb_ahb_sram_slave;

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [31:0] d;
  } tx_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        m_sel;
  logic        m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [2:0]  m_size;
  logic [1:0]  m_trans;
  int          tgt;

  ahb_sram_slave_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();
  ahb_sram_slave_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();

  ahb_sram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .HCLK_i(clk), .HRESETn_i(rstn), .bus(bus0.slave)
  );
  ahb_sram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(3)) dut1 (
    .HCLK_i(clk), .HRESETn_i(rstn), .bus(bus1.slave)
  );

  assign bus0.HSEL     = m_sel && (tgt == 0);
  assign bus0.HADDR_i  = m_addr;
  assign bus0.HWRITE_i = m_write;
  assign bus0.HSIZE_i  = m_size;
  assign bus0.HTRANS_i = m_trans;
  assign bus0.HWDATA_i = m_wdata;
  assign bus0.HREADY_i = bus0.HREADYOUT_o;
  assign bus1.HSEL     = m_sel && (tgt == 1);
  assign bus1.HADDR_i  = m_addr;
  assign bus1.HWRITE_i = m_write;
  assign bus1.HSIZE_i  = m_size;
  assign bus1.HTRANS_i = m_trans;
  assign bus1.HWDATA_i = m_wdata;
  assign bus1.HREADY_i = bus1.HREADYOUT_o;

  logic        o_ready;
  logic        o_resp;
  logic [31:0] o_rdata;
  assign o_ready = (tgt == 1) ? bus1.HREADYOUT_o : bus0.HREADYOUT_o;
  assign o_resp  = (tgt == 1) ? bus1.HRESP_o     : bus0.HRESP_o;
  assign o_rdata = (tgt == 1) ? bus1.HRDATA_o    : bus0.HRDATA_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  ref_mem [2][1024];
  tx_t         txq[$];
  int          res_waits[$];
  bit          res_resp[$];
  bit          res_wresp[$];
  bit          res_rz[$];
  logic [31:0] res_rdata[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_err(input tx_t t);
    bit e;
    e = (t.sz > 3'd2);
`ifdef AHB_SRAM_ADDR_ERR_EN
    if (t.a >= 32'h400) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] ref_word(input int d, input logic [31:0] a);
    int base;
    base = int'(a % 1024) & ~3;
    return {ref_mem[d][base+3], ref_mem[d][base+2], ref_mem[d][base+1], ref_mem[d][base]};
  endfunction

  task automatic ref_apply(input int d, input tx_t t);
    int n;
    int base;
    n    = 1 << t.sz;
    base = int'(t.a % 1024) & ~(n - 1);
    for (int k = 0; k < n; k++) begin
      ref_mem[d][base+k] = t.d[8*((base+k)%4) +: 8];
    end
  endtask

  task automatic drive_addr(input tx_t t);
    m_sel   = 1'b1;
    m_trans = 2'b10;
    m_write = t.w;
    m_addr  = t.a;
    m_size  = t.sz;
  endtask

  task automatic drive_idle();
    m_sel   = 1'b0;
    m_trans = 2'b00;
  endtask

  // Issues every queued transfer back-to-back, holding the next address
  // while the current data phase is stalled.
  task automatic run_txq();
    res_waits.delete(); res_resp.delete(); res_wresp.delete();
    res_rz.delete(); res_rdata.delete();
    @(negedge clk);
    drive_addr(txq[0]);
    for (int i = 0; i < txq.size(); i++) begin
      int waits;
      bit rz;
      bit wr;
      waits = 0; rz = 1'b1; wr = 1'b0;
      @(posedge clk);
      #1;
      m_wdata = txq[i].d;
      if (i + 1 < txq.size()) drive_addr(txq[i+1]);
      else drive_idle();
      @(negedge clk);
      while (o_ready !== 1'b1 && waits < 20) begin
        waits++;
        if (o_rdata !== 32'h0) rz = 1'b0;
        if (o_resp === 1'b1) wr = 1'b1;
        @(negedge clk);
      end
      res_waits.push_back(waits);
      res_resp.push_back(o_resp);
      res_wresp.push_back(wr);
      res_rz.push_back(rz);
      res_rdata.push_back(o_rdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_results(input int d, input string tag);
    for (int i = 0; i < txq.size(); i++) begin
      bit e;
      int exp_w;
      e     = ref_err(txq[i]);
      exp_w = e ? 1 : ((d == 1) ? 3 : 0);
      check($sformatf("%s[%0d].resp", tag, i), 32'(res_resp[i]), 32'(e));
      check($sformatf("%s[%0d].waits", tag, i), 32'(res_waits[i]), 32'(exp_w));
      check($sformatf("%s[%0d].wait_resp", tag, i), 32'(res_wresp[i]), 32'(e));
      check($sformatf("%s[%0d].wait_rdata0", tag, i), 32'(res_rz[i]), 32'd1);
      if (!txq[i].w && !e)
        check($sformatf("%s[%0d].rdata", tag, i), res_rdata[i], ref_word(d, txq[i].a));
      if (txq[i].w && !e) ref_apply(d, txq[i]);
    end
  endtask

  function automatic tx_t mk(input bit w, input logic [31:0] a, input logic [2:0] sz,
                             input logic [31:0] d);
    tx_t t;
    t.w = w; t.a = a; t.sz = sz; t.d = d;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; m_sel = 1'b0; m_write = 1'b0; m_addr = '0; m_wdata = '0;
    m_size = '0; m_trans = '0; tgt = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tgt = d;
      #1;
      check($sformatf("reset.ready%0d", d), 32'(o_ready), 32'd1);
      check($sformatf("reset.resp%0d", d), 32'(o_resp), 32'd0);
      check($sformatf("reset.rdata%0d", d), o_rdata, 32'h0);
    end
    rstn = 1'b1;

    for (int d = 0; d < 2; d++) begin
      tgt = d;
      txq.delete();
      for (int k = 0; k < 16; k++) txq.push_back(mk(1'b1, 32'(4*k), 3'd2, $urandom));
      run_txq();
      check_results(d, "init");
    end

    tgt = 0;
    txq.delete();
    txq.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEADBEEF));
    txq.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0));
    run_txq();
    check_results(0, "b2b");
    check("b2b.rdata_const", res_rdata[1], 32'hDEADBEEF);

    txq.delete();
    txq.push_back(mk(1'b1, 32'h10, 3'd2, 32'h11223344));
    txq.push_back(mk(1'b1, 32'h13, 3'd0, 32'hAA000000));
    txq.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0));
    run_txq();
    check_results(0, "byte");
    check("byte.rdata_const", res_rdata[2], 32'hAA223344);

    tgt = 1;
    txq.delete();
    txq.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0));
    run_txq();
    check_results(1, "wait3");

    tgt = 0;
    txq.delete();
    txq.push_back(mk(1'b1, 32'h0, 3'd2, 32'h55667788));
    txq.push_back(mk(1'b1, 32'h400, 3'd2, 32'h99AABBCC));
    txq.push_back(mk(1'b0, 32'h0, 3'd2, 32'h0));
    txq.push_back(mk(1'b1, 32'h8, 3'd3, 32'h01020304));
    txq.push_back(mk(1'b0, 32'h8, 3'd2, 32'h0));
    run_txq();
    check_results(0, "range");
`ifdef AHB_SRAM_ADDR_ERR_EN
    check("range.rdata_const", res_rdata[2], 32'h55667788);
`else
    check("range.rdata_const", res_rdata[2], 32'h99AABBCC);
`endif

    for (int r = 0; r < 8; r++) begin
      tgt = $urandom % 2;
      txq.delete();
      for (int k = 0; k < 6; k++) begin
        bit w;
        logic [31:0] a;
        logic [2:0] sz;
        w  = $urandom % 2;
        a  = $urandom % 64;
        if ($urandom % 8 == 0) a = 32'h400 + ($urandom % 64);
        sz = ($urandom % 8 == 0) ? 3'd3 : 3'($urandom % 3);
        txq.push_back(mk(w, a, sz, $urandom));
      end
      run_txq();
      check_results(tgt, $sformatf("rnd%0d", r));
    end

    tgt = 1;
    txq.delete();
    txq.push_back(mk(1'b1, 32'h20, 3'd2, 32'hCAFEF00D));
    run_txq();
    check_results(1, "pre_rst");
    @(negedge clk);
    drive_addr(mk(1'b1, 32'h20, 3'd2, 32'h0));
    @(posedge clk);
    #1;
    m_wdata = 32'h12345678;
    drive_idle();
    @(negedge clk);
    check("rst.in_wait_ready", 32'(o_ready), 32'd0);
    rstn = 1'b0;
    @(negedge clk);
    check("rst.ready", 32'(o_ready), 32'd1);
    check("rst.resp", 32'(o_resp), 32'd0);
    check("rst.rdata", o_rdata, 32'h0);
    rstn = 1'b1;
    txq.delete();
    txq.push_back(mk(1'b0, 32'h20, 3'd2, 32'h0));
    run_txq();
    check_results(1, "post_rst");
    check("post_rst.rdata_const", res_rdata[0], 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter DATA_W, 32, data bus width in bits (32 or 64).
REQ-002 SHALL have parameter ADDR_W, 32, address bus width in bits.
REQ-003 SHALL have parameter DEPTH, 256, memory depth in DATA_W-bit words.
REQ-004 SHALL have parameter WAIT_CYCLES, 0, wait states inserted per NONSEQ/SEQ transfer (0..7).
REQ-005 SHALL have port HCLK_i, input, 1, single clock; all logic on the rising edge.
REQ-006 SHALL have port HRESETn_i, input, 1, reset, synchronous and active-low.
REQ-007 SHALL have port HSEL, input, 1, slave select.
REQ-008 SHALL have port HADDR_i, input, ADDR_W, byte address.
REQ-009 SHALL have port HWRITE_i, input, 1, 1 = write, 0 = read.
REQ-010 SHALL have port HSIZE_i, input, 3, transfer size (000 = byte, 001 = half, 010 = word, 011 = dword).
REQ-011 SHALL have port HTRANS_i, input, 2, transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-012 SHALL have port HREADY_i, input, 1, bus-level ready.
REQ-013 SHALL have port HWDATA_i, input, DATA_W, write data, sampled in the data phase.
REQ-014 SHALL have port HREADYOUT_o, output, 1, slave transfer-complete.
REQ-015 SHALL have port HRESP_o, output, 1, 0 = OKAY, 1 = ERROR.
REQ-016 SHALL have port HRDATA_o, output, DATA_W, read data.

Function
REQ-017 Address phase SHALL be accepted only when HSEL && HREADY_i && HTRANS_i[1] at a clock edge; it SHALL register address, write, and size.
REQ-018 IDLE/BUSY transfers or HSEL=0 SHALL produce a zero-wait OKAY response: HREADYOUT_o=1, HRESP_o=0.
REQ-019 FSM states SHALL be IDLE, WAIT, DATA, ERR1, ERR2.
- IDLE: accepted valid transfer goes to WAIT if WAIT_CYCLES>0, otherwise to DATA; error goes to ERR1.
REQ-020 WAIT SHALL hold HREADYOUT_o=0 for exactly WAIT_CYCLES cycles (down-counter), then go to DATA.
REQ-021 DATA SHALL drive HREADYOUT_o=1 and HRESP_o=0; it SHALL return to IDLE, or accept the next pipelined address phase in the same cycle (back-to-back, no bubble when WAIT_CYCLES=0).
REQ-022 Write SHALL commit HWDATA_i byte lanes at the edge ending DATA.
- Lanes are selected by HSIZE and HADDR low bits (little-endian).
- Other lanes of the word are unchanged.
REQ-023 Read SHALL present the full addressed word on HRDATA_o while in DATA; it SHALL be 0 in all other states.
REQ-024 A read directly following a write to the same word SHALL return the newly written bytes (forwarding).
REQ-025 Word index SHALL be HADDR[log2(DEPTH)+log2(DATA_W/8)-1 : log2(DATA_W/8)].
REQ-026 An unaligned address for the given HSIZE SHALL be treated as the aligned-down address; no error.
REQ-027 HSIZE_i greater than log2(DATA_W/8) SHALL produce an ERROR response with no write.

Reset
REQ-028 On HRESETn_i=0 at an edge: HREADYOUT_o=1, HRESP_o=0, HRDATA_o=0, FSM=IDLE, wait counter=0.
REQ-029 Reset mid-transfer SHALL abort the transfer with no memory write; memory contents are not reset.

Configuration
REQ-030 With macro AHB_SRAM_ADDR_ERR_EN defined, an address at or beyond DEPTH words SHALL give the two-cycle ERROR response:
- ERR1: HREADYOUT_o=0, HRESP_o=1.
- ERR2: HREADYOUT_o=1, HRESP_o=1.
- No write, HRDATA_o=0, then IDLE.
REQ-031 Without AHB_SRAM_ADDR_ERR_EN, out-of-range addresses SHALL wrap modulo DEPTH with an OKAY response.

Verification (DATA_W=32, DEPTH=256)
REQ-032 WAIT_CYCLES=0: write word 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> read data 0xDEADBEEF, HREADYOUT_o never low.
REQ-033 Byte write 0xAA to 0x13 over word 0x11223344 -> read 0xAA223344.
REQ-034 WAIT_CYCLES=3: read -> exactly 3 cycles of HREADYOUT_o=0, then data with OKAY.
REQ-035 AHB_SRAM_ADDR_ERR_EN defined: write to 0x400 -> ERR1/ERR2 sequence and memory unchanged; undefined -> OKAY, data aliases word 0.
REQ-036 HRESETn_i=0 asserted during a WAIT of a write -> outputs at reset values next cycle, target word unchanged.
